// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue stage: control codes, op fields, FSM states.
package alu_issue_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_LESS = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic       ainvert;
    logic       bnegate;
    logic [1:0] op;
  } ctl_fields_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU control decode: raw bit-field mapping plus a legality flag.
module alu_ctl_decode
  import alu_issue_pkg::*;
(
  input  logic [3:0] ctl_i,
  output logic       ainvert_o,
  output logic       bnegate_o,
  output logic [1:0] op_o,
  output logic       legal_o
);

  assign ainvert_o = ctl_i[3];
  assign bnegate_o = ctl_i[2];
  assign op_o      = ctl_i[1:0];

  always_comb begin
    legal_o = 1'b0;
    case (ctl_i)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: legal_o = 1'b1;
      default:                                             legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage ahead of the N-bit ALU: decode on entry, 2-entry skid buffer.
// Optional illegal-code trap is enabled by defining ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [1:0]       alu_op,
  output logic             illegal_op
);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  ctl_fields_t dec_fields;
  logic        dec_legal;
  logic        accept, push, pop;
  logic        load_main_in, load_main_skid, load_skid;

  ctl_fields_t     main_ctl_q, skid_ctl_q;
  logic [WIDTH-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;

  alu_ctl_decode u_decode (
    .ctl_i     (in_ctl),
    .ainvert_o (dec_fields.ainvert),
    .bnegate_o (dec_fields.bnegate),
    .op_o      (dec_fields.op),
    .legal_o   (dec_legal)
  );

  // A trapped code completes its handshake but never enters the buffer.
  assign accept = in_valid && in_ready_q;
  assign push   = accept && (dec_legal || !TRAP_EN);
  assign pop    = (state_q != EMPTY) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = BUSY;
      BUSY: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so it never sees out_ready combinationally.
  always_comb begin
    in_ready_d     = (state_d != FULL);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: load_main_in = push;
      BUSY: begin
        load_main_in = push && pop;
        load_skid    = push && !pop;
      end
      FULL:    load_main_skid = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctl_q <= '0;
      main_a_q   <= '0;
      main_b_q   <= '0;
      skid_ctl_q <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
    end else begin
      if (load_main_in) begin
        main_ctl_q <= dec_fields;
        main_a_q   <= in_a;
        main_b_q   <= in_b;
      end else if (load_main_skid) begin
        main_ctl_q <= skid_ctl_q;
        main_a_q   <= skid_a_q;
        main_b_q   <= skid_b_q;
      end
      if (load_skid) begin
        skid_ctl_q <= dec_fields;
        skid_a_q   <= in_a;
        skid_b_q   <= in_b;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic illegal_op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op_q <= 1'b0;
    else        illegal_op_q <= accept && !dec_legal;
  end

  assign illegal_op = illegal_op_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign alu_in1     = main_a_q;
  assign alu_in2     = main_b_q;
  assign alu_ainvert = main_ctl_q.ainvert;
  assign alu_bnegate = main_ctl_q.bnegate;
  assign alu_op      = main_ctl_q.op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus randomized valid/ready traffic.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN the same way the design does.
module tb_alu_issue_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_ctl = 4'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_in1, alu_in2;
  logic         alu_ainvert, alu_bnegate;
  logic [1:0]   alu_op;
  logic         illegal_op;

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  req_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   illegal_pend = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   done = 1'b0;
  int   issued = 0;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] c);
    return c == 4'b0000 || c == 4'b0001 || c == 4'b0010 ||
           c == 4'b0110 || c == 4'b0111 || c == 4'b1100;
  endfunction

  // What the operation means arithmetically, independent of the control encoding.
  function automatic logic [W-1:0] semantic(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return d;
      4'b0111: return {{(W-1){1'b0}}, d[W-1]};
      default: return ~(a | b);
    endcase
  endfunction

  // Behaviour of the downstream ALU given its control inputs.
  function automatic logic [W-1:0] alu_fn(input logic ai, input logic bn, input logic [1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, s;
    x = ai ? ~a : a;
    y = bn ? ~b : b;
    s = x + y + {{(W-1){1'b0}}, bn};
    case (op)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return s;
      default: return {{(W-1){1'b0}}, s[W-1]};
    endcase
  endfunction

  // Monitor: judges the cycle's handshakes from values held stable before the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      illegal_pend = 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, illegal_pend});
      illegal_pend = 1'b0;
      if (out_valid && sb.size() != 0) begin
        chk("alu_in1", alu_in1, sb[0].a);
        chk("alu_in2", alu_in2, sb[0].b);
        chk("alu_ctl", {28'd0, alu_ainvert, alu_bnegate, alu_op}, {28'd0, sb[0].ctl});
        if (out_ready) begin
          if (is_legal(sb[0].ctl))
            chk("alu_result", alu_fn(alu_ainvert, alu_bnegate, alu_op, alu_in1, alu_in2),
                semantic(sb[0].ctl, sb[0].a, sb[0].b));
          $display("ISSUE ctl=%b a=%h b=%h", sb[0].ctl, sb[0].a, sb[0].b);
          void'(sb.pop_front());
          issued++;
        end
      end
      if (in_valid && in_ready) begin
        if (TRAP && !is_legal(in_ctl)) illegal_pend = 1'b1;
        else sb.push_back('{ctl: in_ctl, a: in_a, b: in_b});
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1; in_ctl = c; in_a = a; in_b = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 99) < 70);
    end
  end

  initial begin
    logic [3:0] legal_tab [6];
    logic [3:0] c;
    legal_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", {alu_in1 | alu_in2} | {28'd0, alu_ainvert, alu_bnegate, alu_op}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Single ADD with 1-cycle latency
    out_ready = 1'b1;
    send(4'b0010, 32'd5, 32'd3);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    chk("add_result", alu_fn(alu_ainvert, alu_bnegate, alu_op, alu_in1, alu_in2), 32'd8);
    cycles(1);

    // Back-to-back SUB/SLT/NOR
    send(4'b0110, 32'd3, 32'd5);
    chk("sub_result", alu_fn(alu_ainvert, alu_bnegate, alu_op, alu_in1, alu_in2), 32'hFFFF_FFFE);
    send(4'b0111, 32'd3, 32'd5);
    chk("slt_fields", {29'd0, alu_bnegate, alu_op}, 32'b111);
    send(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("nor_fields", {28'd0, alu_ainvert, alu_bnegate, alu_op}, 32'b1100);
    cycles(2);

    // Backpressure: two fill the buffer, third stalls until release
    out_ready = 1'b0;
    send(4'b0000, 32'hAAAA_5555, 32'hFFFF_0000);
    send(4'b0001, 32'h1234_0000, 32'h0000_5678);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    fork
      send(4'b0010, 32'd100, 32'd23);
      begin
        cycles(4);
        out_ready = 1'b1;
      end
    join
    drain();

    // Async reset while FULL
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd1);
    send(4'b0010, 32'd2, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(3);
    chk("no_stale", {31'd0, out_valid}, 32'd0);

    // Illegal code 1010
    send(4'b1010, 32'd7, 32'd9);
    cycles(3);
    drain();

    // Random traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 99) < 30) cycles(1);
      if ($urandom_range(0, 99) < 85) c = legal_tab[$urandom_range(0, 5)];
      else c = 4'($urandom_range(0, 15));
      send(c, $urandom, $urandom);
    end
    rand_rdy = 1'b0;
    drain();
    cycles(2);
    chk("issued_any", {31'd0, issued > 9000}, 32'd1);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    if (!done) begin
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
    end
  end

endmodule
